// File: rtl/trackball_quad_if.sv
// Mouse/control inputs and quadrature outputs of trackball_quad, bundled as one bus.
interface trackball_quad_if #(
    parameter int DIV_W = 3
);
    logic [24:0]      ps2_mouse;
    logic [DIV_W-1:0] sense;
    logic             flip;
    logic             pause;
    logic [3:0]       joy;
    logic [3:0]       trak_o;
    logic             busy_o;

    modport master (
        output ps2_mouse, sense, flip, pause, joy,
        input  trak_o, busy_o
    );

    modport slave (
        input  ps2_mouse, sense, flip, pause, joy,
        output trak_o, busy_o
    );
endinterface

// File: rtl/trackball_quad.sv
// PS/2 motion -> trackball dir/step-toggle emulation; first step on the first divider tick after the packet is registered, no backpressure.
// Optional TRACKBALL_JOY_EN: joystick steps an idle axis on each tick.
module trackball_quad #(
    parameter int ACC_W = 12,
    parameter int DIV_W = 3
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    trackball_quad_if.slave  bus
);
    localparam logic signed [ACC_W-1:0] ONE = {{(ACC_W-1){1'b0}}, 1'b1};

    logic signed [ACC_W-1:0] acc_x, acc_y, acc_x_nxt, acc_y_nxt;
    logic signed [ACC_W-1:0] dx, dy;
    logic [DIV_W-1:0]        div;
    logic                    old_toggle, busy;
    logic                    x_dir, x_clk, y_dir, y_clk;
    logic                    x_dir_nxt, x_clk_nxt, y_dir_nxt, y_clk_nxt;
    logic                    pkt, tick, sx, sy;
    logic                    mouse_unused;

    assign mouse_unused = ^{bus.ps2_mouse[7:6], bus.ps2_mouse[3:0]};

    assign pkt  = bus.ps2_mouse[24] ^ old_toggle;
    assign tick = (div == bus.sense) && !bus.pause;
    assign sx   = bus.ps2_mouse[4] ^ bus.flip;
    assign sy   = bus.ps2_mouse[5] ^ bus.flip;
    assign dx   = {{(ACC_W-8){sx}}, bus.ps2_mouse[15:8]};
    assign dy   = {{(ACC_W-8){sy}}, bus.ps2_mouse[23:16]};

`ifndef TRACKBALL_JOY_EN
    logic joy_unused;
    assign joy_unused = ^bus.joy;
`endif

    // Packet add is gated while the top two bits differ, so the accumulator can never wrap.
    always_comb begin
        acc_x_nxt = acc_x;
        x_dir_nxt = x_dir;
        x_clk_nxt = x_clk;
        if (pkt && (acc_x[ACC_W-1] == acc_x[ACC_W-2]))
            acc_x_nxt = acc_x + dx;
        if (tick) begin
            if (acc_x != '0) begin
                acc_x_nxt = acc_x[ACC_W-1] ? acc_x_nxt + ONE : acc_x_nxt - ONE;
                x_dir_nxt = ~acc_x[ACC_W-1];
                x_clk_nxt = ~x_clk;
            end
`ifdef TRACKBALL_JOY_EN
            else if (bus.joy[3] ^ bus.joy[2]) begin
                x_dir_nxt = bus.joy[3] ^ bus.flip;
                x_clk_nxt = ~x_clk;
            end
`endif
        end
    end

    always_comb begin
        acc_y_nxt = acc_y;
        y_dir_nxt = y_dir;
        y_clk_nxt = y_clk;
        if (pkt && (acc_y[ACC_W-1] == acc_y[ACC_W-2]))
            acc_y_nxt = acc_y + dy;
        if (tick) begin
            if (acc_y != '0) begin
                acc_y_nxt = acc_y[ACC_W-1] ? acc_y_nxt + ONE : acc_y_nxt - ONE;
                y_dir_nxt = ~acc_y[ACC_W-1];
                y_clk_nxt = ~y_clk;
            end
`ifdef TRACKBALL_JOY_EN
            else if (bus.joy[0] ^ bus.joy[1]) begin
                y_dir_nxt = bus.joy[0] ^ bus.flip;
                y_clk_nxt = ~y_clk;
            end
`endif
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            acc_x      <= '0;
            acc_y      <= '0;
            div        <= '0;
            old_toggle <= bus.ps2_mouse[24];
            x_dir      <= 1'b0;
            x_clk      <= 1'b0;
            y_dir      <= 1'b0;
            y_clk      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            old_toggle <= bus.ps2_mouse[24];
            acc_x      <= acc_x_nxt;
            acc_y      <= acc_y_nxt;
            x_dir      <= x_dir_nxt;
            x_clk      <= x_clk_nxt;
            y_dir      <= y_dir_nxt;
            y_clk      <= y_clk_nxt;
            busy       <= (acc_x != '0) || (acc_y != '0);
            if (tick)
                div <= '0;
            else if (!bus.pause)
                div <= div + 1'b1;
        end
    end

    assign bus.trak_o = {x_dir, x_clk, y_dir, y_clk};
    assign bus.busy_o = busy;
endmodule

// File: tb/tb_trackball_quad.sv
// Bench for trackball_quad: fixed single-packet vectors, corner sequences, randomized run against a motion model.
module tb_trackball_quad;
    localparam int ACC_W = 12;
    localparam int DIV_W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    trackball_quad_if #(.DIV_W(DIV_W)) bus();

    trackball_quad #(.ACC_W(ACC_W), .DIV_W(DIV_W)) dut (
        .clk_sys (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: signed integer counts per axis, a phase counter for step opportunities.
    int m_ax, m_ay, m_div;
    bit m_old, m_xd, m_xc, m_yd, m_yc, m_busy;

    function automatic int delta(input bit s, input bit [7:0] m);
        return s ? int'(m) - 256 : int'(m);
    endfunction

    function automatic bit fits(input int a);
        return (a >= -(1 << (ACC_W-2))) && (a < (1 << (ACC_W-2)));
    endfunction

    function automatic void model_edge();
        bit pkt, tick;
        int ax0, ay0;
        if (!rst_n) begin
            m_ax = 0; m_ay = 0; m_div = 0;
            m_xd = 0; m_xc = 0; m_yd = 0; m_yc = 0; m_busy = 0;
            m_old = bus.ps2_mouse[24];
        end else begin
            pkt   = (bus.ps2_mouse[24] != m_old);
            m_old = bus.ps2_mouse[24];
            tick  = !bus.pause && (m_div == int'(bus.sense));
            ax0 = m_ax;
            ay0 = m_ay;
            m_busy = (ax0 != 0) || (ay0 != 0);
            if (pkt && fits(ax0)) m_ax += delta(bus.ps2_mouse[4] ^ bus.flip, bus.ps2_mouse[15:8]);
            if (pkt && fits(ay0)) m_ay += delta(bus.ps2_mouse[5] ^ bus.flip, bus.ps2_mouse[23:16]);
            if (tick) begin
                if (ax0 != 0) begin
                    m_ax += (ax0 > 0) ? -1 : 1;
                    m_xd = (ax0 > 0);
                    m_xc = !m_xc;
                end
`ifdef TRACKBALL_JOY_EN
                else if (bus.joy[3] != bus.joy[2]) begin
                    m_xd = bus.joy[3] ^ bus.flip;
                    m_xc = !m_xc;
                end
`endif
                if (ay0 != 0) begin
                    m_ay += (ay0 > 0) ? -1 : 1;
                    m_yd = (ay0 > 0);
                    m_yc = !m_yc;
                end
`ifdef TRACKBALL_JOY_EN
                else if (bus.joy[0] != bus.joy[1]) begin
                    m_yd = bus.joy[0] ^ bus.flip;
                    m_yc = !m_yc;
                end
`endif
            end
            if (tick) m_div = 0;
            else if (!bus.pause) m_div = (m_div + 1) % (1 << DIV_W);
        end
    endfunction

    int cyc_no = 0;
    int x_tog, y_tog, x_last, y_last, gap_exp;
    bit gap_bad, xc_prev, yc_prev;

    task automatic clr_counts();
        x_tog = 0; y_tog = 0; x_last = -1; y_last = -1; gap_bad = 0;
        xc_prev = bus.trak_o[2];
        yc_prev = bus.trak_o[0];
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        cyc_no++;
        if (bus.trak_o[2] != xc_prev) begin
            x_tog++;
            if (x_last >= 0 && cyc_no - x_last != gap_exp) gap_bad = 1;
            x_last = cyc_no;
        end
        if (bus.trak_o[0] != yc_prev) begin
            y_tog++;
            if (y_last >= 0 && cyc_no - y_last != gap_exp) gap_bad = 1;
            y_last = cyc_no;
        end
        xc_prev = bus.trak_o[2];
        yc_prev = bus.trak_o[0];
    endtask

    task automatic send(input bit sx, input bit [7:0] mx, input bit sy, input bit [7:0] my);
        bus.ps2_mouse = {~bus.ps2_mouse[24], my, mx, 2'b00, sy, sx, 4'b0000};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    typedef struct {
        bit       axis;   // 0 = x, 1 = y
        bit       sgn;
        bit [7:0] mag;
        bit       flip;
        int       sense;
        int       steps;
        bit       dir;
    } vec_t;

    vec_t vec[7];

    initial begin
        int budget;
        bit fl;

        vec[0] = '{0, 1'b0, 8'h03, 1'b0, 0,   3, 1'b1};
        vec[1] = '{0, 1'b1, 8'hFE, 1'b0, 7,   2, 1'b0};
        vec[2] = '{1, 1'b0, 8'h05, 1'b1, 0, 251, 1'b0};  // flipped sign: {1,0x05} is -251
        vec[3] = '{1, 1'b0, 8'h05, 1'b0, 2,   5, 1'b1};
        vec[4] = '{0, 1'b1, 8'h00, 1'b0, 1, 256, 1'b0};
        vec[5] = '{1, 1'b1, 8'hFF, 1'b1, 3, 255, 1'b1};
        vec[6] = '{0, 1'b0, 8'h00, 1'b0, 5,   0, 1'b0};

        bus.ps2_mouse = '0;
        bus.sense     = '0;
        bus.flip      = 1'b0;
        bus.pause     = 1'b0;
        bus.joy       = 4'b0000;
        gap_exp       = 1;

        rst_n = 1'b0;
        cyc();
        cyc();
        chk("reset_trak", int'(bus.trak_o), 0);
        chk("reset_busy", int'(bus.busy_o), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_reset();
            bus.sense = DIV_W'(vec[i].sense);
            bus.flip  = vec[i].flip;
            bus.pause = 1'b0;
            gap_exp   = vec[i].sense + 1;
            clr_counts();
            fl = vec[i].flip;
            if (vec[i].axis == 0) send(vec[i].sgn, vec[i].mag, fl, 8'h00);
            else                  send(fl, 8'h00, vec[i].sgn, vec[i].mag);
            cyc();
            budget = (vec[i].sense + 1) * vec[i].steps + 30;
            for (int c = 0; c < budget; c++) cyc();
            if (vec[i].axis == 0) begin
                chk($sformatf("v%0d_steps", i), x_tog, vec[i].steps);
                chk($sformatf("v%0d_other", i), y_tog, 0);
                chk($sformatf("v%0d_dir", i), int'(bus.trak_o[3]), int'(vec[i].dir));
            end else begin
                chk($sformatf("v%0d_steps", i), y_tog, vec[i].steps);
                chk($sformatf("v%0d_other", i), x_tog, 0);
                chk($sformatf("v%0d_dir", i), int'(bus.trak_o[1]), int'(vec[i].dir));
            end
            chk($sformatf("v%0d_gap", i), int'(gap_bad), 0);
            chk($sformatf("v%0d_busy", i), int'(bus.busy_o), 0);
        end
        bus.flip = 1'b0;

        // Saturation while paused: 9 packets of +127 reach 1143, further packets are dropped.
        do_reset();
        bus.sense = '0;
        bus.pause = 1'b1;
        gap_exp   = 1;
        clr_counts();
        for (int p = 0; p < 20; p++) begin
            send(1'b0, 8'd127, 1'b0, 8'h00);
            cyc();
        end
        cyc();
        chk("sat_acc", int'(dut.acc_x), 1143);
        chk("sat_no_toggle", x_tog, 0);
        bus.pause = 1'b0;
        clr_counts();
        for (int c = 0; c < 1143 + 20; c++) cyc();
        chk("sat_replay", x_tog, 1143);
        chk("sat_busy", int'(bus.busy_o), 0);

        // Packet on the same edge as a step with acc_x=1.
        do_reset();
        bus.sense = '0;
        clr_counts();
        send(1'b0, 8'd1, 1'b0, 8'h00);
        cyc();
        chk("coinc_pre_acc", int'(dut.acc_x), 1);
        chk("coinc_pre_tog", x_tog, 0);
        send(1'b0, 8'd4, 1'b0, 8'h00);
        cyc();
        chk("coinc_acc", int'(dut.acc_x), 4);
        chk("coinc_tog", x_tog, 1);
        chk("coinc_dir", int'(bus.trak_o[3]), 1);

        // Reset mid-replay, with a packet toggle arriving during reset.
        do_reset();
        bus.pause = 1'b1;
        send(1'b0, 8'd50, 1'b0, 8'h00);
        cyc();
        bus.pause = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b0;
        send(1'b0, 8'd50, 1'b0, 8'h00);
        cyc();
        chk("rst_trak", int'(bus.trak_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        rst_n = 1'b1;
        clr_counts();
        for (int c = 0; c < 10; c++) cyc();
        chk("rst_no_toggle", x_tog, 0);
        chk("rst_acc", int'(dut.acc_x), 0);
        chk("rst_busy_after", int'(bus.busy_o), 0);

        // Randomized run, compared every cycle against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0)
                send(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
            if ($urandom_range(0, 63) == 0) bus.sense = DIV_W'($urandom);
            if ($urandom_range(0, 99) == 0) bus.flip  = ~bus.flip;
            if ($urandom_range(0, 49) == 0) bus.pause = ~bus.pause;
            if ($urandom_range(0, 31) == 0) bus.joy   = 4'($urandom);
            rst_n = ($urandom_range(0, 999) != 0);
            cyc();
            chk("rnd_trak", int'(bus.trak_o), int'({m_xd, m_xc, m_yd, m_yc}));
            chk("rnd_busy", int'(bus.busy_o), int'(m_busy));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
